// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus signals between one master and one SRAM responder.
// Handshake: an address phase is taken on a rising edge where HSEL, HTRANS[1]
// and HREADY are all high; the data phase that follows ends on the first
// rising edge where HREADYOUT is high. HRESP qualifies that data phase.
interface ahb_lite_bus_if #(
  parameter int ADDR_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite word-addressed SRAM responder with a fixed number of wait states
// before every OKAY completion and a two-cycle ERROR response for bad
// addresses, sizes or alignment. Writes commit on the edge that closes an
// OKAY data phase; reads are combinational from the registered word index.
module ahb_lite_sram_slave #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic           HCLK,
  input  logic           HRESET,
  ahb_lite_bus_if.slave  bus,
  output logic [1:0]     dbg_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  // One bit wider than HADDR so DEPTH*4 always fits in the range compare.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * 4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;   // an OKAY transfer owns the data phase
  logic               write_q;
  logic [IDX_W-1:0]   idx_q;
  logic [3:0]         mask_q;

  logic [31:0]        mem [DEPTH];

  logic               hready_int;
  logic               accept;
  logic               size_bad, range_bad, align_bad, req_err;
  logic [3:0]         mask_d;
  logic               commit;
  logic               unused_bits;

  // HTRANS[0] only distinguishes SEQ from NONSEQ, which are treated alike.
  assign unused_bits = bus.HTRANS[0];

  // Request decode: accept qualification, error classification, lane mask.
  always_comb begin
    hready_int = (state_q == S_IDLE) || (state_q == S_ERR2);
    accept     = bus.HSEL & bus.HTRANS[1] & bus.HREADY & hready_int;
    size_bad   = (bus.HSIZE > 3'b010);
    range_bad  = ({1'b0, bus.HADDR} >= LIMIT);
    align_bad  = ((bus.HSIZE == 3'b001) && bus.HADDR[0]) ||
                 ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00));
    req_err    = size_bad | range_bad | align_bad;
    mask_d     = 4'b0000;
    case (bus.HSIZE)
      3'b000:  mask_d = 4'b0001 << bus.HADDR[1:0];
      3'b001:  mask_d = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      3'b010:  mask_d = 4'b1111;
      default: mask_d = 4'b0000;
    endcase
  end

  // Next-state logic: data-phase sequencing for OKAY waits and ERROR pairs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        // Final data cycle (or no transfer): a new accept starts the next phase.
        state_d = S_IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
        if (accept) begin
          if (req_err) begin
            state_d = S_ERR1;
          end else begin
            pend_d = 1'b1;
            if (WAIT_STATES > 0) begin
              state_d = S_WAIT;
              cnt_d   = CNT_W'(WAIT_STATES);
            end
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State and address-phase capture registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
      mask_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (accept) begin
        write_q <= bus.HWRITE;
        idx_q   <= bus.HADDR[IDX_W+1:2];
        mask_q  <= mask_d;
      end
    end
  end

  // A write lands only on the edge closing its OKAY data phase.
  assign commit = (state_q == S_IDLE) && pend_q && write_q;

  // Byte-lane write into the array; contents survive reset.
  always_ff @(posedge HCLK) begin
    if (!HRESET && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) begin
          mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign bus.HREADYOUT = hready_int;
  assign bus.HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign bus.HRDATA    = ((state_q == S_IDLE) && pend_q && !write_q) ? mem[idx_q] : 32'h0;
  assign dbg_state     = state_q;

endmodule
